// File: rtl/fetch_unit_mo.sv
// ---------------------------------------------------------------------------
// fetch_unit_mo
//
// Multi-outstanding instruction fetch unit. Issues block-aligned fetch
// requests to instruction memory and keeps up to MAX_OUTSTANDING blocks
// either in flight or buffered. Returned blocks are delivered in order to
// the instruction queue together with their block PC and first valid slot.
// A redirect toggles an epoch bit. In-flight responses that carry the old
// epoch are dropped as they return, so the memory pipeline never has to
// drain.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_redirect_valid/_pc        one-cycle redirect pulse and the new PC
//   o_mem_req_valid/_addr       registered fetch request (block aligned)
//   i_mem_req_ready             memory accepts the request
//   i_mem_resp_valid/_data      in-order response, never back-pressured
//   o_iq_valid, i_iq_ready      block handshake toward the instruction queue
//   o_iq_instruction_flatten    block data, slot i at [i*DATA +: DATA]
//   o_iq_pc                     block-aligned PC of the delivered block
//   o_iq_slot_lowerbound        first valid slot (redirect into mid-block)
// ---------------------------------------------------------------------------
module fetch_unit_mo #(
    parameter int                    BW_PROCESSOR_DATA  = 32,
    parameter int                    BW_PROCESSOR_BLOCK = 64,
    parameter int                    BW_ADDRESS         = 32,
    parameter int                    MAX_OUTSTANDING    = 4,
    parameter logic [BW_ADDRESS-1:0] RESET_PC           = '0,
    localparam int                   NUM_SLOT           = BW_PROCESSOR_BLOCK / BW_PROCESSOR_DATA,
    localparam int                   BW_SLOT            = (NUM_SLOT > 1) ? $clog2(NUM_SLOT) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_redirect_valid,
    input  logic [BW_ADDRESS-1:0]         i_redirect_pc,
    output logic                          o_mem_req_valid,
    input  logic                          i_mem_req_ready,
    output logic [BW_ADDRESS-1:0]         o_mem_req_addr,
    input  logic                          i_mem_resp_valid,
    input  logic [BW_PROCESSOR_BLOCK-1:0] i_mem_resp_data,
    output logic                          o_iq_valid,
    input  logic                          i_iq_ready,
    output logic [BW_PROCESSOR_BLOCK-1:0] o_iq_instruction_flatten,
    output logic [BW_ADDRESS-1:0]         o_iq_pc,
    output logic [BW_SLOT-1:0]            o_iq_slot_lowerbound
);

    localparam int BLK_BYTES = BW_PROCESSOR_BLOCK / 8;
    localparam int PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W     = PTR_W + 1;

    localparam logic [BW_ADDRESS-1:0] BLK_INC    = BW_ADDRESS'(BLK_BYTES);
    localparam logic [BW_ADDRESS-1:0] ALIGN_MASK = ~(BLK_INC - BW_ADDRESS'(1));
    localparam logic [CNT_W:0]        CREDIT_MAX = (CNT_W + 1)'(MAX_OUTSTANDING);
    localparam logic [BW_SLOT-1:0]    SLOT_MASK  = BW_SLOT'(NUM_SLOT - 1);

    // Control state
    logic [BW_ADDRESS-1:0] fetch_pc_q, fetch_pc_d;
    logic                  epoch_q, epoch_d;
    logic                  first_q, first_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;

    // Registered request
    logic                  req_valid_q, req_valid_d;
    logic [BW_ADDRESS-1:0] req_addr_q, req_addr_d;
    logic [BW_SLOT-1:0]    req_lb_q, req_lb_d;
    logic                  req_epoch_q, req_epoch_d;

    // Tag FIFO pointers (occupancy equals inflight_q)
    logic [PTR_W-1:0]      tag_wr_q, tag_wr_d;
    logic [PTR_W-1:0]      tag_rd_q, tag_rd_d;

    // Response buffer pointers and count
    logic [PTR_W-1:0]      buf_wr_q, buf_wr_d;
    logic [PTR_W-1:0]      buf_rd_q, buf_rd_d;
    logic [CNT_W-1:0]      buf_count_q, buf_count_d;

    // Storage arrays: data only, never reset
    logic                          tag_epoch_mem [MAX_OUTSTANDING];
    logic [BW_ADDRESS-1:0]         tag_addr_mem  [MAX_OUTSTANDING];
    logic [BW_SLOT-1:0]            tag_lb_mem    [MAX_OUTSTANDING];
    logic [BW_PROCESSOR_BLOCK-1:0] buf_data_mem  [MAX_OUTSTANDING];
    logic [BW_ADDRESS-1:0]         buf_pc_mem    [MAX_OUTSTANDING];
    logic [BW_SLOT-1:0]            buf_lb_mem    [MAX_OUTSTANDING];

    logic                  req_fire;
    logic                  resp_live;
    logic                  buf_nonempty;
    logic                  iq_valid;
    logic                  iq_pop;
    logic                  slot_free;
    logic                  req_load;
    logic [CNT_W:0]        credit_sum;
    logic [BW_ADDRESS-1:0] fetch_pc_aligned;
    logic [BW_SLOT-1:0]    first_lb;

    always_comb begin
        req_fire         = req_valid_q && i_mem_req_ready;
        // A response arriving in a redirect cycle is stale regardless of tag.
        resp_live        = i_mem_resp_valid && !i_redirect_valid
                           && (tag_epoch_mem[tag_rd_q] == epoch_q);
        buf_nonempty     = (buf_count_q != '0);
        iq_valid         = buf_nonempty && !i_redirect_valid;
        iq_pop           = iq_valid && i_iq_ready;
        fetch_pc_aligned = fetch_pc_q & ALIGN_MASK;
        first_lb         = BW_SLOT'(fetch_pc_q >> 2) & SLOT_MASK;

        inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(i_mem_resp_valid);
        tag_wr_d   = tag_wr_q + PTR_W'(req_fire);
        tag_rd_d   = tag_rd_q + PTR_W'(i_mem_resp_valid);
        epoch_d    = epoch_q ^ i_redirect_valid;

        if (i_redirect_valid) begin
            buf_count_d = '0;
            buf_wr_d    = '0;
            buf_rd_d    = '0;
        end else begin
            buf_count_d = buf_count_q + CNT_W'(resp_live) - CNT_W'(iq_pop);
            buf_wr_d    = buf_wr_q + PTR_W'(resp_live);
            buf_rd_d    = buf_rd_q + PTR_W'(iq_pop);
        end

        // Credit is judged on next-cycle occupancy, so a request presented
        // next cycle always satisfies inflight + buffered < MAX_OUTSTANDING.
        // That sum can only shrink while the request waits for ready.
        credit_sum = {1'b0, inflight_d} + {1'b0, buf_count_d};
        slot_free  = !req_valid_q || req_fire;
        req_load   = slot_free && !i_redirect_valid && (credit_sum < CREDIT_MAX);

        fetch_pc_d  = fetch_pc_q;
        first_d     = first_q;
        req_valid_d = req_valid_q && !req_fire;
        req_addr_d  = req_addr_q;
        req_lb_d    = req_lb_q;
        req_epoch_d = req_epoch_q;

        if (req_load) begin
            req_valid_d = 1'b1;
            req_addr_d  = fetch_pc_aligned;
            req_lb_d    = first_q ? first_lb : '0;
            req_epoch_d = epoch_q;
            fetch_pc_d  = fetch_pc_aligned + BLK_INC;
            first_d     = 1'b0;
        end

        // A held request is left untouched; it completes with its old epoch.
        if (i_redirect_valid) begin
            fetch_pc_d = i_redirect_pc;
            first_d    = 1'b1;
        end
    end

    // Register stage: control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            epoch_q     <= 1'b0;
            first_q     <= 1'b1;
            inflight_q  <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_lb_q    <= '0;
            req_epoch_q <= 1'b0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            buf_wr_q    <= '0;
            buf_rd_q    <= '0;
            buf_count_q <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            epoch_q     <= epoch_d;
            first_q     <= first_d;
            inflight_q  <= inflight_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_lb_q    <= req_lb_d;
            req_epoch_q <= req_epoch_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
            buf_wr_q    <= buf_wr_d;
            buf_rd_q    <= buf_rd_d;
            buf_count_q <= buf_count_d;
        end
    end

    // Register stage: tag FIFO and response buffer storage
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_epoch_mem[tag_wr_q] <= req_epoch_q;
            tag_addr_mem[tag_wr_q]  <= req_addr_q;
            tag_lb_mem[tag_wr_q]    <= req_lb_q;
        end
        if (resp_live) begin
            buf_data_mem[buf_wr_q] <= i_mem_resp_data;
            buf_pc_mem[buf_wr_q]   <= tag_addr_mem[tag_rd_q];
            buf_lb_mem[buf_wr_q]   <= tag_lb_mem[tag_rd_q];
        end
    end

    assign o_mem_req_valid = req_valid_q;
    assign o_mem_req_addr  = req_addr_q;
    assign o_iq_valid      = iq_valid;

    // Outputs read as zero while the buffer is empty, including out of reset.
    assign o_iq_instruction_flatten = buf_nonempty ? buf_data_mem[buf_rd_q] : '0;
    assign o_iq_pc                  = buf_nonempty ? buf_pc_mem[buf_rd_q]   : '0;
    assign o_iq_slot_lowerbound     = buf_nonempty ? buf_lb_mem[buf_rd_q]   : '0;

endmodule

// File: tb/tb_fetch_unit_mo.sv
module tb_fetch_unit_mo;

    localparam int BW_SLOT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [31:0] o_mem_req_addr;
    logic        i_mem_resp_valid;
    logic [63:0] i_mem_resp_data;
    logic        o_iq_valid;
    logic        i_iq_ready;
    logic [63:0] o_iq_instruction_flatten;
    logic [31:0] o_iq_pc;
    logic [BW_SLOT-1:0] o_iq_slot_lowerbound;

    fetch_unit_mo dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .i_redirect_valid         (i_redirect_valid),
        .i_redirect_pc            (i_redirect_pc),
        .o_mem_req_valid          (o_mem_req_valid),
        .i_mem_req_ready          (i_mem_req_ready),
        .o_mem_req_addr           (o_mem_req_addr),
        .i_mem_resp_valid         (i_mem_resp_valid),
        .i_mem_resp_data          (i_mem_resp_data),
        .o_iq_valid               (o_iq_valid),
        .i_iq_ready               (i_iq_ready),
        .o_iq_instruction_flatten (o_iq_instruction_flatten),
        .o_iq_pc                  (o_iq_pc),
        .o_iq_slot_lowerbound     (o_iq_slot_lowerbound)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int lat         = 2;

    logic [31:0]        req_log[$];
    int                 req_cyc[$];
    logic [31:0]        iq_pc_log[$];
    logic [BW_SLOT-1:0] iq_lb_log[$];
    logic [63:0]        iq_data_log[$];
    int                 iq_cyc[$];
    logic [31:0]        pend_addr[$];
    int                 pend_due[$];

    function automatic logic [63:0] mkdata(input logic [31:0] a);
        return {a ^ 32'hDEADBEEF, a};
    endfunction

    function automatic logic [31:0] req_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 'x;
    endfunction

    function automatic logic [31:0] pc_at(input int i);
        if (i < iq_pc_log.size()) return iq_pc_log[i];
        return 'x;
    endfunction

    function automatic logic [BW_SLOT-1:0] lb_at(input int i);
        if (i < iq_lb_log.size()) return iq_lb_log[i];
        return 'x;
    endfunction

    function automatic logic [63:0] data_at(input int i);
        if (i < iq_data_log.size()) return iq_data_log[i];
        return 'x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes on the falling edge, then after the
    // rising edge drive the memory response that is due this cycle.
    task automatic step();
        @(negedge clk);
        if (o_mem_req_valid && i_mem_req_ready) begin
            req_log.push_back(o_mem_req_addr);
            req_cyc.push_back(cyc);
            pend_addr.push_back(o_mem_req_addr);
            pend_due.push_back(cyc + lat);
        end
        if (o_iq_valid && i_iq_ready) begin
            iq_pc_log.push_back(o_iq_pc);
            iq_lb_log.push_back(o_iq_slot_lowerbound);
            iq_data_log.push_back(o_iq_instruction_flatten);
            iq_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        i_mem_resp_valid = 1'b0;
        i_mem_resp_data  = '0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            i_mem_resp_valid = 1'b1;
            i_mem_resp_data  = mkdata(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
    endtask

    task automatic clear_iq_logs();
        iq_pc_log.delete();
        iq_lb_log.delete();
        iq_data_log.delete();
        iq_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        i_mem_req_ready  = 1'b0;
        i_iq_ready       = 1'b0;
        i_mem_resp_valid = 1'b0;
        i_mem_resp_data  = '0;
        pend_addr.delete();
        pend_due.delete();
        step();
        step();
        rst_n = 1'b1;
        req_log.delete();
        req_cyc.delete();
        clear_iq_logs();
        cyc = 0;
    endtask

    initial begin
        int nd;
        int lat_obs;
        int gap_obs;

        rst_n            = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        i_mem_req_ready  = 1'b0;
        i_iq_ready       = 1'b0;
        i_mem_resp_valid = 1'b0;
        i_mem_resp_data  = '0;
        #2;
        chk("rst_req_valid", 64'(o_mem_req_valid), 64'(0));
        chk("rst_req_addr",  64'(o_mem_req_addr), 64'(0));
        chk("rst_iq_valid",  64'(o_iq_valid), 64'(0));
        chk("rst_iq_pc",     64'(o_iq_pc), 64'(0));
        chk("rst_iq_lb",     64'(o_iq_slot_lowerbound), 64'(0));
        chk("rst_iq_data",   o_iq_instruction_flatten, 64'(0));

        // Straight-line fetch
        do_reset();
        lat = 2; i_mem_req_ready = 1'b1; i_iq_ready = 1'b1;
        repeat (12) step();
        chk("line_req0", 64'(req_at(0)), 64'(32'h0));
        chk("line_req1", 64'(req_at(1)), 64'(32'h8));
        chk("line_req2", 64'(req_at(2)), 64'(32'h10));
        chk("line_req4", 64'(req_at(4)), 64'(32'h20));
        chk("line_pc0",  64'(pc_at(0)), 64'(32'h0));
        chk("line_pc1",  64'(pc_at(1)), 64'(32'h8));
        chk("line_pc2",  64'(pc_at(2)), 64'(32'h10));
        chk("line_lb0",  64'(lb_at(0)), 64'(0));
        chk("line_lb2",  64'(lb_at(2)), 64'(0));
        chk("line_data1", data_at(1), 64'hDEADBEE7_00000008);
        lat_obs = (iq_cyc.size() > 0 && req_cyc.size() > 0) ? iq_cyc[0] - req_cyc[0] : -1;
        chk("line_latency", 64'(lat_obs), 64'(3));
        gap_obs = (iq_cyc.size() > 2) ? iq_cyc[2] - iq_cyc[0] : -1;
        chk("line_throughput", 64'(gap_obs), 64'(2));

        // Credit limit
        do_reset();
        lat = 2; i_mem_req_ready = 1'b1; i_iq_ready = 1'b0;
        repeat (10) step();
        chk("credit_count", 64'(req_log.size()), 64'(4));
        chk("credit_req3",  64'(req_at(3)), 64'(32'h18));
        chk("credit_stop",  64'(o_mem_req_valid), 64'(0));
        chk("credit_iq_v",  64'(o_iq_valid), 64'(1));
        chk("credit_head",  64'(o_iq_pc), 64'(32'h0));
        i_iq_ready = 1'b1;
        step();
        i_iq_ready = 1'b0;
        repeat (8) step();
        chk("credit_pop_pc", 64'(pc_at(0)), 64'(32'h0));
        chk("credit_count2", 64'(req_log.size()), 64'(5));
        chk("credit_req4",   64'(req_at(4)), 64'(32'h20));
        chk("credit_stop2",  64'(o_mem_req_valid), 64'(0));
        chk("credit_head2",  64'(o_iq_pc), 64'(32'h8));

        // Redirect with three requests in flight
        do_reset();
        lat = 6; i_mem_req_ready = 1'b1; i_iq_ready = 1'b1;
        for (int k = 0; k < 20 && req_log.size() < 2; k++) step();
        i_redirect_valid = 1'b1; i_redirect_pc = 32'h104;
        step();
        i_redirect_valid = 1'b0;
        chk("redir_inflight", 64'(req_log.size()), 64'(3));
        repeat (25) step();
        chk("redir_req3",  64'(req_at(3)), 64'(32'h100));
        chk("redir_req4",  64'(req_at(4)), 64'(32'h108));
        chk("redir_pc0",   64'(pc_at(0)), 64'(32'h100));
        chk("redir_lb0",   64'(lb_at(0)), 64'(1));
        chk("redir_data0", data_at(0), 64'hDEADBFEF_00000100);
        chk("redir_pc1",   64'(pc_at(1)), 64'(32'h108));
        chk("redir_lb1",   64'(lb_at(1)), 64'(0));

        // Redirect while a request is stalled
        do_reset();
        lat = 3; i_mem_req_ready = 1'b1; i_iq_ready = 1'b1;
        for (int k = 0; k < 20 && req_log.size() < 3; k++) step();
        i_mem_req_ready = 1'b0;
        step();
        step();
        chk("stall_valid", 64'(o_mem_req_valid), 64'(1));
        chk("stall_addr",  64'(o_mem_req_addr), 64'(32'h18));
        clear_iq_logs();
        i_redirect_valid = 1'b1; i_redirect_pc = 32'h204;
        step();
        i_redirect_valid = 1'b0;
        chk("stall_hold_addr",  64'(o_mem_req_addr), 64'(32'h18));
        chk("stall_hold_valid", 64'(o_mem_req_valid), 64'(1));
        step();
        step();
        chk("stall_hold_addr2", 64'(o_mem_req_addr), 64'(32'h18));
        i_mem_req_ready = 1'b1;
        repeat (25) step();
        chk("stall_req3", 64'(req_at(3)), 64'(32'h18));
        chk("stall_req4", 64'(req_at(4)), 64'(32'h200));
        chk("stall_pc0",  64'(pc_at(0)), 64'(32'h200));
        chk("stall_lb0",  64'(lb_at(0)), 64'(1));
        chk("stall_pc1",  64'(pc_at(1)), 64'(32'h208));

        // Redirect coinciding with a response and an IQ pop
        do_reset();
        lat = 2; i_mem_req_ready = 1'b1; i_iq_ready = 1'b1;
        for (int k = 0; k < 20 && !(i_mem_resp_valid && o_iq_valid); k++) step();
        chk("coinc_setup", 64'(i_mem_resp_valid && o_iq_valid), 64'(1));
        nd = iq_pc_log.size();
        i_redirect_valid = 1'b1; i_redirect_pc = 32'h300;
        #1;
        chk("coinc_iq_valid", 64'(o_iq_valid), 64'(0));
        step();
        i_redirect_valid = 1'b0;
        chk("coinc_no_deliver", 64'(iq_pc_log.size()), 64'(nd));
        chk("coinc_empty",      64'(o_iq_valid), 64'(0));
        repeat (20) step();
        chk("coinc_next_pc", 64'(pc_at(nd)), 64'(32'h300));

        // Address wrap
        do_reset();
        lat = 2; i_mem_req_ready = 1'b1; i_iq_ready = 1'b1;
        i_redirect_valid = 1'b1; i_redirect_pc = 32'hFFFF_FFF8;
        step();
        i_redirect_valid = 1'b0;
        repeat (15) step();
        chk("wrap_req0", 64'(req_at(0)), 64'(32'hFFFF_FFF8));
        chk("wrap_req1", 64'(req_at(1)), 64'(32'h0));
        chk("wrap_pc0",  64'(pc_at(0)), 64'(32'hFFFF_FFF8));
        chk("wrap_pc1",  64'(pc_at(1)), 64'(32'h0));
        chk("wrap_lb0",  64'(lb_at(0)), 64'(0));

        // Reset asserted mid-operation clears immediately
        rst_n = 1'b0;
        #1;
        chk("midrst_req_valid", 64'(o_mem_req_valid), 64'(0));
        chk("midrst_req_addr",  64'(o_mem_req_addr), 64'(0));
        chk("midrst_iq_valid",  64'(o_iq_valid), 64'(0));
        do_reset();
        lat = 2; i_mem_req_ready = 1'b1; i_iq_ready = 1'b1;
        repeat (4) step();
        chk("midrst_req0", 64'(req_at(0)), 64'(32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit_mo.md
Name: fetch_unit_mo

Overview:
Multi-outstanding instruction fetch unit for the Tomasulo processor front end. It issues block-aligned fetch requests on a split request/response instruction-memory interface, keeping up to MAX_OUTSTANDING requests in flight. Returned blocks are buffered in order and delivered to the instruction queue with their PC and first-valid-slot index. Branch redirects are handled with an epoch tag that squashes stale in-flight responses without draining the memory pipeline.

Parameters:
BW_PROCESSOR_DATA, 32, instruction width in bits
BW_PROCESSOR_BLOCK, 64, fetch block width in bits; must be a power-of-two multiple of BW_PROCESSOR_DATA
BW_ADDRESS, 32, byte address width
MAX_OUTSTANDING, 4, maximum of (requests in flight + blocks buffered); power of two, >=2
RESET_PC, 0, fetch address after reset; word aligned
NUM_SLOT (derived), BW_PROCESSOR_BLOCK/BW_PROCESSOR_DATA, instructions per block
BW_SLOT (derived), max(1, clog2(NUM_SLOT)), slot index width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_redirect_valid  input  1  one-cycle pulse: mispredict or redirect
i_redirect_pc  input  BW_ADDRESS  corrected next PC; word aligned
o_mem_req_valid  output  1  fetch request valid
i_mem_req_ready  input  1  memory accepts request
o_mem_req_addr  output  BW_ADDRESS  block-aligned request address
i_mem_resp_valid  input  1  response valid; in order, at most one per cycle, never back-pressured
i_mem_resp_data  input  BW_PROCESSOR_BLOCK  fetched block
o_iq_valid  output  1  block available to IQ
i_iq_ready  input  1  IQ accepts block
o_iq_instruction_flatten  output  BW_PROCESSOR_BLOCK  block data; slot i at [i*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA]
o_iq_pc  output  BW_ADDRESS  block-aligned PC of the delivered block
o_iq_slot_lowerbound  output  BW_SLOT  first valid slot; nonzero only for a block entered mid-block by a redirect

Behaviour:
- Reset: fetch_pc=RESET_PC, epoch=0, inflight=0, buffer empty, o_mem_req_valid=0, o_mem_req_addr=0, o_iq_valid=0. All other outputs are 0.
- Credit rule: a new request is presented only when inflight + buf_count < MAX_OUTSTANDING.
  - inflight increments on a request handshake and decrements on any response, stale or not.
  - This guarantees the response buffer never overflows.
- Request: o_mem_req_addr = fetch_pc with the low log2(BLOCK bytes) bits cleared. Each request is tagged with the current epoch in an internal tag FIFO of depth MAX_OUTSTANDING.
  - On handshake: fetch_pc <= aligned fetch_pc + BW_PROCESSOR_BLOCK/8. Wraps modulo 2^BW_ADDRESS.
  - The request is registered. While o_mem_req_valid && !i_mem_req_ready, the address and valid must hold stable, including across a redirect. The held request completes with its old epoch and its response is later dropped.
- Response: pop the tag FIFO.
  - If tag == epoch, push {data, block pc, lowerbound} into the response buffer (depth MAX_OUTSTANDING). The lowerbound is captured at request time.
  - Otherwise discard the response.
- Lowerbound: the first request after reset or a redirect carries fetch_pc[BW_SLOT+1:2]. All subsequent requests carry 0.
- IQ output: o_iq_valid = buffer non-empty && !i_redirect_valid. The head is popped on o_iq_valid && i_iq_ready. Data is driven directly from the buffer head, with zero added latency.
- Redirect (cycle T):
  - Toggle epoch.
  - Flush the response buffer (buf_count=0).
  - fetch_pc <= i_redirect_pc.
  - inflight is unchanged.
  - Any response arriving in cycle T is treated as stale.
  - The first request using the new PC is presented no earlier than T+1, subject to the credit rule and to any held request completing.
- Simultaneous push and pop of the buffer in the same cycle: count is unchanged, and full/empty are computed from the pre-cycle count.
- Minimum latency: request handshake at T with response at T+k gives o_iq_valid at T+k+1. The buffer is registered; bypass is not required.
- Throughput: one block per cycle sustained when memory and IQ are always ready and latency < MAX_OUTSTANDING.
- Reset asserted mid-operation: all state clears immediately. Responses for requests issued before reset are the environment's responsibility; the bench must not send them.

Test Plan:
- Straight-line fetch: RESET_PC=0, mem ready, 2-cycle latency, IQ ready → requests 0x0,0x8,0x10,…; IQ receives the blocks in order with o_iq_pc 0x0,0x8,0x10 and lowerbound 0.
- Credit limit: IQ not ready, MAX_OUTSTANDING=4 → exactly 4 handshakes, then o_mem_req_valid=0. After one IQ pop, exactly one new request is issued.
- Redirect with 3 in flight: redirect to 0x104 → the 3 stale responses are dropped. The next request address is 0x100, and the IQ's first block shows o_iq_pc=0x100, lowerbound=1. The following block has lowerbound=0.
- Redirect while a request is stalled (i_mem_req_ready=0 at addr 0x18): the address holds at 0x18 until accepted and its response is dropped. The next request is at the redirect target.
- Simultaneous redirect with a response and an IQ pop in the same cycle: o_iq_valid=0 in that cycle, nothing is delivered, and the buffer empties.
- Address wrap: redirect to 0xFFFFFFF8 → requests 0xFFFFFFF8 then 0x0.
